voter_id_verifier: RTL and testbench

//  Parametrised voter/officer ID verifier for the EVM. It checks a requested ID against a

---
 rtl/voter_id_verifier.sv | 133 +++++++++++++
 tb/tb_voter_id_verifier.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voter_id_verifier.sv
// Voter/officer ID verifier: searches the voter table one entry per clock, tracks voted flags,
// handles officer login/logout and authorised clearing, and strobes valid voters to the vote RAM.
module voter_id_verifier #(
    parameter int                    WORD_SIZE    = 5,
    parameter int                    ADDRESS_SIZE = 4,
    parameter int                    NUM_VOTERS   = 16,
    parameter int                    ID_BASE      = 0,
    parameter logic [WORD_SIZE-1:0]  OFFICER_ID   = 5'b11111,
    parameter logic [WORD_SIZE-1:0]  RESET_ID     = 5'b11110
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [1:0]              req_type,
    input  logic [WORD_SIZE-1:0]    id_in,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              result,
    output logic                    officer_active,
    output logic                    write,
    output logic [ADDRESS_SIZE-1:0] valid_voter_address,
    output logic [WORD_SIZE-1:0]    valid_voter,
    output logic [ADDRESS_SIZE:0]   vote_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [2:0] R_VALID       = 3'b001;
    localparam logic [2:0] R_UNKNOWN     = 3'b010;
    localparam logic [2:0] R_DUPLICATE   = 3'b011;
    localparam logic [2:0] R_OFFICER_OK  = 3'b100;
    localparam logic [2:0] R_OFFICER_BAD = 3'b101;
    localparam logic [2:0] R_CLEAR_OK    = 3'b110;
    localparam logic [2:0] R_DENIED      = 3'b111;

    localparam logic [ADDRESS_SIZE-1:0] LAST_IDX = ADDRESS_SIZE'(NUM_VOTERS - 1);

    logic [1:0]                       state;
    logic [ADDRESS_SIZE-1:0]          idx;
    logic [WORD_SIZE-1:0]             cap_id;
    // Sized to the full address space so idx always selects a real bit; entries past
    // NUM_VOTERS are never searched and so never set.
    logic [(1<<ADDRESS_SIZE)-1:0]     voted;
    logic [WORD_SIZE-1:0]             entry_id;

    // Table contents are implicit: entry i holds ID_BASE+i, wrapping at the ID width.
    assign entry_id = WORD_SIZE'(ID_BASE) + WORD_SIZE'(idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            idx                 <= '0;
            cap_id              <= '0;
            voted               <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            result              <= '0;
            officer_active      <= 1'b0;
            write               <= 1'b0;
            valid_voter_address <= '0;
            valid_voter         <= '0;
            vote_count          <= '0;
        end else begin
            done   <= 1'b0;
            write  <= 1'b0;
            result <= '0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_id <= id_in;
                        idx    <= '0;
                        state  <= S_REPORT;
                        done   <= 1'b1;
                        case (req_type)
                            2'b00: begin
                                if (officer_active) begin
                                    state <= S_SEARCH;
                                    busy  <= 1'b1;
                                    done  <= 1'b0;
                                end else begin
                                    result <= R_DENIED;
                                end
                            end
                            2'b01: begin
                                officer_active <= (id_in == OFFICER_ID);
                                result <= (id_in == OFFICER_ID) ? R_OFFICER_OK : R_OFFICER_BAD;
                            end
                            2'b10: begin
                                if (officer_active && id_in == RESET_ID) begin
                                    voted      <= '0;
                                    vote_count <= '0;
                                    result     <= R_CLEAR_OK;
                                end else begin
                                    result <= R_DENIED;
                                end
                            end
                            default: result <= R_DENIED;
                        endcase
                    end
                end
                S_SEARCH: begin
                    if (entry_id == cap_id) begin
                        state <= S_REPORT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!voted[idx]) begin
                            voted[idx]          <= 1'b1;
                            vote_count          <= vote_count + (ADDRESS_SIZE+1)'(1);
                            result              <= R_VALID;
                            write               <= 1'b1;
                            valid_voter_address <= idx;
                            valid_voter         <= cap_id;
                        end else begin
                            result <= R_DUPLICATE;
                        end
                    end else if (idx == LAST_IDX) begin
                        state  <= S_REPORT;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= R_UNKNOWN;
                    end else begin
                        idx <= idx + ADDRESS_SIZE'(1);
                    end
                end
                S_REPORT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voter_id_verifier.sv
// Bench for voter_id_verifier: two configurations share one stimulus stream and are checked
// every cycle against a transaction-level model, plus literal expectations for known scenarios.
module tb_voter_id_verifier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [1:0] req_type = 2'b00;
    logic [4:0] id_in = '0;

    logic       busy_w [2];
    logic       done_w [2];
    logic [2:0] result_w [2];
    logic       oa_w [2];
    logic       write_w [2];
    logic [3:0] addr_w [2];
    logic [4:0] vid_w [2];
    logic [4:0] vc_w [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    voter_id_verifier dut0 (
        .clk(clk), .rst(rst), .req(req), .req_type(req_type), .id_in(id_in),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
        .officer_active(oa_w[0]), .write(write_w[0]),
        .valid_voter_address(addr_w[0]), .valid_voter(vid_w[0]), .vote_count(vc_w[0])
    );

    voter_id_verifier #(.NUM_VOTERS(4), .ID_BASE(8)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_type(req_type), .id_in(id_in),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
        .officer_active(oa_w[1]), .write(write_w[1]),
        .valid_voter_address(addr_w[1]), .valid_voter(vid_w[1]), .vote_count(vc_w[1])
    );

    // Reference model: a request is resolved in full at acceptance (result + latency);
    // its side effects land on the edge the report becomes visible.
    int       NV [2]   = '{16, 4};
    int       BASE [2] = '{0, 8};
    bit       m_voted [2][16];
    bit       m_oa [2];
    int       m_wait [2];
    bit       m_rep [2];
    int       p_res [2];
    int       p_k [2];
    int       p_id [2];
    int       m_addr [2];
    int       m_vid [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_oa[d] = 0; m_wait[d] = 0; m_rep[d] = 0; m_addr[d] = 0; m_vid[d] = 0;
            p_res[d] = 0; p_k[d] = 0; p_id[d] = 0;
            for (int i = 0; i < 16; i++) m_voted[d][i] = 0;
        end
    end

    function automatic int count_voted(input int d);
        int c = 0;
        for (int i = 0; i < 16; i++) c += m_voted[d][i];
        return c;
    endfunction

    task automatic model_report(input int d);
        m_rep[d] = 1;
        case (p_res[d])
            1: begin m_voted[d][p_k[d]] = 1; m_addr[d] = p_k[d]; m_vid[d] = p_id[d]; end
            4: m_oa[d] = 1;
            5: m_oa[d] = 0;
            6: for (int i = 0; i < 16; i++) m_voted[d][i] = 0;
            default: ;
        endcase
    endtask

    task automatic model_step(input int d);
        int lat, k, id;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_voted[d][i] = 0;
            m_oa[d] = 0; m_wait[d] = 0; m_rep[d] = 0; m_addr[d] = 0; m_vid[d] = 0;
        end else if (m_rep[d]) begin
            m_rep[d] = 0;
        end else if (m_wait[d] > 0) begin
            m_wait[d]--;
            if (m_wait[d] == 0) model_report(d);
        end else if (req) begin
            id = int'(id_in);
            lat = 1;
            p_id[d] = id;
            case (req_type)
                2'b00: begin
                    if (!m_oa[d]) p_res[d] = 7;
                    else begin
                        k = -1;
                        for (int i = 0; i < NV[d]; i++)
                            if (k < 0 && ((BASE[d] + i) % 32) == id) k = i;
                        if (k < 0) begin p_res[d] = 2; lat = NV[d] + 1; end
                        else begin
                            p_k[d] = k; lat = k + 2;
                            p_res[d] = m_voted[d][k] ? 3 : 1;
                        end
                    end
                end
                2'b01: p_res[d] = (id == 31) ? 4 : 5;
                2'b10: p_res[d] = (m_oa[d] && id == 30) ? 6 : 7;
                default: p_res[d] = 7;
            endcase
            if (lat == 1) model_report(d);
            else m_wait[d] = lat - 1;
        end
    endtask

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 32'(busy_w[d]), 32'(m_wait[d] > 0));
            chk("done", d, 32'(done_w[d]), 32'(m_rep[d]));
            chk("result", d, 32'(result_w[d]), m_rep[d] ? 32'(p_res[d]) : 32'd0);
            chk("write", d, 32'(write_w[d]), 32'(m_rep[d] && p_res[d] == 1));
            chk("officer_active", d, 32'(oa_w[d]), 32'(m_oa[d]));
            chk("address", d, 32'(addr_w[d]), 32'(m_addr[d]));
            chk("valid_voter", d, 32'(vid_w[d]), 32'(m_vid[d]));
            chk("vote_count", d, 32'(vc_w[d]), 32'(count_voted(d)));
        end
    end

    // Issues one request with both DUTs idle; reports what dut d showed on its first done.
    task automatic txn(input logic [1:0] rt, input logic [4:0] id, input int d, input bit hold,
                       output int lat, output logic [2:0] res, output logic wr,
                       output logic [3:0] addr, output logic [4:0] vc, output logic oa,
                       output int ndone);
        @(negedge clk);
        req = 1'b1; req_type = rt; id_in = id;
        lat = -1; ndone = 0; res = '0; wr = 1'b0; addr = '0; vc = '0; oa = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (!hold || lat >= 0) req = 1'b0;
            if (done_w[d] === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = n; res = result_w[d]; wr = write_w[d];
                    addr = addr_w[d]; vc = vc_w[d]; oa = oa_w[d];
                end
            end
        end
        req = 1'b0;
        if (lat < 0) chk("done_timeout", d, 32'd0, 32'd1);
    endtask

    initial begin
        int lat, nd;
        logic [2:0] res;
        logic wr, oa;
        logic [3:0] addr;
        logic [4:0] vc;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("rst_done", 0, 32'(done_w[0]), 32'd0);
        chk("rst_result", 0, 32'(result_w[0]), 32'd0);
        chk("rst_vote_count", 0, 32'(vc_w[0]), 32'd0);

        txn(2'b00, 5'b00011, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("nologin_lat", 0, 32'(lat), 32'd1);
        chk("nologin_res", 0, 32'(res), 32'b111);
        chk("nologin_write", 0, 32'(wr), 32'd0);

        txn(2'b01, 5'b11111, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("login_res", 0, 32'(res), 32'b100);
        chk("login_oa", 0, 32'(oa), 32'd1);

        txn(2'b00, 5'b00011, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("valid_lat", 0, 32'(lat), 32'd5);
        chk("valid_res", 0, 32'(res), 32'b001);
        chk("valid_write", 0, 32'(wr), 32'd1);
        chk("valid_addr", 0, 32'(addr), 32'd3);
        chk("valid_vc", 0, 32'(vc), 32'd1);

        txn(2'b00, 5'b00011, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("dup_res", 0, 32'(res), 32'b011);
        chk("dup_write", 0, 32'(wr), 32'd0);
        chk("dup_vc", 0, 32'(vc), 32'd1);

        txn(2'b00, 5'b10101, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("unknown_res", 0, 32'(res), 32'b010);
        chk("unknown_lat", 0, 32'(lat), 32'd17);

        txn(2'b10, 5'b11110, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("clear_res", 0, 32'(res), 32'b110);
        chk("clear_vc", 0, 32'(vc), 32'd0);

        txn(2'b00, 5'b00011, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("revote_res", 0, 32'(res), 32'b001);

        txn(2'b00, 5'b01011, 1, 0, lat, res, wr, addr, vc, oa, nd);
        chk("small_valid_res", 1, 32'(res), 32'b001);
        chk("small_valid_addr", 1, 32'(addr), 32'd3);
        txn(2'b00, 5'b01100, 1, 0, lat, res, wr, addr, vc, oa, nd);
        chk("small_unknown_res", 1, 32'(res), 32'b010);
        chk("small_unknown_lat", 1, 32'(lat), 32'd5);

        txn(2'b00, 5'b00100, 0, 1, lat, res, wr, addr, vc, oa, nd);
        chk("held_req_res", 0, 32'(res), 32'b001);
        chk("held_req_ndone", 0, 32'(nd), 32'd1);

        // Reset in the middle of a long search.
        @(negedge clk);
        req = 1'b1; req_type = 2'b00; id_in = 5'b10101;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("midrst_oa", 0, 32'(oa_w[0]), 32'd0);
        chk("midrst_vc", 0, 32'(vc_w[0]), 32'd0);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || write_w[0] !== 1'b0) nd++;
        end
        chk("midrst_no_done", 0, 32'(nd), 32'd0);

        txn(2'b01, 5'b11111, 0, 0, lat, res, wr, addr, vc, oa, nd);
        txn(2'b01, 5'b00000, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("logout_res", 0, 32'(res), 32'b101);
        chk("logout_oa", 0, 32'(oa), 32'd0);
        txn(2'b10, 5'b11110, 0, 0, lat, res, wr, addr, vc, oa, nd);
        chk("clear_denied_res", 0, 32'(res), 32'b111);

        // Randomized traffic; the per-cycle model comparison does the checking.
        repeat (4000) begin
            @(negedge clk);
            rst = ($urandom_range(299) == 0);
            req = ($urandom_range(2) == 0);
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: begin
                    req_type = 2'b00;
                    case ($urandom_range(3))
                        0: id_in = 5'(8 + $urandom_range(3));
                        1, 2: id_in = 5'($urandom_range(15));
                        default: id_in = 5'($urandom);
                    endcase
                end
                6, 7: begin
                    req_type = 2'b01;
                    id_in = ($urandom_range(2) != 0) ? 5'b11111 : 5'($urandom);
                end
                8: begin
                    req_type = 2'b10;
                    id_in = ($urandom_range(3) != 0) ? 5'b11110 : 5'($urandom);
                end
                default: begin
                    req_type = 2'b11;
                    id_in = 5'($urandom);
                end
            endcase
        end
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
